// File: rtl/uint_to_l1_if.sv
// Valid/ready bundle between an integer producer, uint_to_l1 and its L1 consumer.
`timescale 1ns/1ps
interface uint_to_l1_if #(
   parameter int unsigned W_VAL    = 288,
   parameter int unsigned ADD_DIV  = 4,
   parameter int unsigned L1_CARRY = 2
);
   localparam int unsigned OutW = ADD_DIV * (W_VAL / ADD_DIV + L1_CARRY);

   logic             in_valid;
   logic             in_ready;
   logic [W_VAL-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OutW-1:0]  out_data;
   logic             out_err;

   // Producer/consumer side.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   // Converter side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/uint_to_l1.sv
// Unsigned integer to redundant L1 polynomial ingress converter. Reduces the operand into
// [0, M) by at most MAX_MULT-1 conditional subtractions, then splits it into ADD_DIV limbs
// with zeroed carry fields. Operands at or above MAX_MULT*M are flagged with out_err.
`timescale 1ns/1ps
module uint_to_l1 #(
   parameter int unsigned     W_VAL    = 288,
   parameter int unsigned     ADD_DIV  = 4,
   parameter int unsigned     L1_CARRY = 2,
   // Default is the BN254 base-field prime, standing in for PARAMS_BN254_d0::M_tilde.
   parameter logic [W_VAL-1:0] M = W_VAL'(
      256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47),
   parameter int unsigned     MAX_MULT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   uint_to_l1_if.slave bus,
   output logic        busy_o
);
   localparam int unsigned LIMB_W  = W_VAL / ADD_DIV;
   localparam int unsigned LimbOut = LIMB_W + L1_CARRY;
   localparam int unsigned OutW    = ADD_DIV * LimbOut;
   localparam int unsigned CntW    = (MAX_MULT > 1) ? $clog2(MAX_MULT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MAX_MULT - 1);

   typedef enum logic [1:0] {StIdle, StReduce, StOut} state_e;

   state_e           state_q, state_d;
   logic [W_VAL-1:0] acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [OutW-1:0]  out_data_q, out_data_d;
   logic             out_err_q, out_err_d;
   logic             out_valid_q, out_valid_d;

   logic [W_VAL:0]   diff;
   logic             acc_ge_m;
   logic             in_ready;
   logic             accept;
   logic [OutW-1:0]  l1_pack;

   // One extra bit so the compare-by-subtraction cannot wrap.
   always_comb begin
      diff     = {1'b0, acc_q} - {1'b0, M};
      acc_ge_m = ~diff[W_VAL];
   end

   // Limb split of the accumulator; carry fields stay zero.
   always_comb begin
      l1_pack = '0;
      for (int i = 0; i < int'(ADD_DIV); i++) begin
         l1_pack[i*LimbOut +: LIMB_W] = acc_q[i*LIMB_W +: LIMB_W];
      end
   end

   // Input readiness: free in IDLE, pass-through of out_ready while a result drains.
   always_comb begin
      unique case (state_q)
         StIdle:  in_ready = 1'b1;
         StOut:   in_ready = bus.out_ready;
         default: in_ready = 1'b0;
      endcase
      accept = bus.in_valid & in_ready;
   end

   // Next-state logic for the reduce/emit FSM.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               acc_d   = bus.in_data;
               cnt_d   = '0;
               state_d = StReduce;
            end
         end
         StReduce: begin
            if (acc_ge_m && (cnt_q != CntLast)) begin
               acc_d = diff[W_VAL-1:0];
               cnt_d = cnt_q + 1'b1;
            end else if (acc_ge_m) begin
               // Still >= M after the allowed subtractions: contract violation.
               out_data_d  = '0;
               out_err_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end else begin
               out_data_d  = l1_pack;
               out_err_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end
         end
         StOut: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               if (accept) begin
                  acc_d   = bus.in_data;
                  cnt_d   = '0;
                  state_d = StReduce;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_err_q   <= out_err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;
   assign busy_o        = (state_q != StIdle);
endmodule

// File: tb/tb_uint_to_l1.sv
// Bench for uint_to_l1: directed boundary/handshake/reset cases, then a random stream with
// back-pressure checked against an arithmetic (mod M) scoreboard.
`timescale 1ns/1ps
module tb_uint_to_l1;
   localparam int unsigned W   = 288;
   localparam int unsigned AD  = 4;
   localparam int unsigned CW  = 2;
   localparam int unsigned LW  = W / AD;
   localparam int unsigned OW  = AD * (LW + CW);
   localparam int unsigned MM  = 4;
   localparam logic [W-1:0] M  = W'(
      256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47);
   localparam logic [W-1:0] M4 = M * 4;
   localparam int unsigned NOps = 1500;

   logic clk;
   logic rst;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   uint_to_l1_if #(.W_VAL(W), .ADD_DIV(AD), .L1_CARRY(CW)) bus ();

   uint_to_l1 #(
      .W_VAL(W), .ADD_DIV(AD), .L1_CARRY(CW), .M(M), .MAX_MULT(MM)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus),
      .busy_o (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Expected L1 image: limbs of (v mod M), or all-zero for contract violations.
   function automatic logic [OW-1:0] model_data(input logic [W-1:0] v);
      logic [OW-1:0] r;
      logic [W-1:0]  red;
      r = '0;
      if (v >= M4) return r;
      red = v % M;
      for (int i = 0; i < int'(AD); i++) r[i*(LW+CW) +: LW] = red[i*LW +: LW];
      return r;
   endfunction

   function automatic int model_lat(input logic [W-1:0] v);
      logic [W-1:0] q;
      if (v >= M4) return MM;
      q = v / M;
      return int'(q[7:0]) + 1;
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offers d at the next negedge, checks it is accepted, and returns edges to out_valid.
   task automatic run_op(input logic [W-1:0] d, output int lat);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = 1'b0;
      #1;
      check("accept_ready", 512'(bus.in_ready), 512'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = rand_w();  // must be ignored after the accept edge
      wait_result(lat);
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("drain_valid", 512'(bus.out_valid), 512'(0));
      bus.out_ready = 1'b0;
   endtask

   task automatic directed(input string tag, input logic [W-1:0] d);
      int lat;
      run_op(d, lat);
      check({tag, "_lat"}, 512'(lat), 512'(model_lat(d)));
      check({tag, "_data"}, 512'(bus.out_data), 512'(model_data(d)));
      check({tag, "_err"}, 512'(bus.out_err), 512'(d >= M4));
      drain();
   endtask

   logic [W-1:0]  op;
   logic [OW-1:0] exp_q[$];
   logic          err_q[$];
   logic [OW-1:0] carry_mask;
   int            lat;
   int            sent;
   int            cyc;

   initial begin
      carry_mask = '0;
      for (int i = 0; i < int'(AD); i++) carry_mask[i*(LW+CW) + LW +: CW] = '1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_valid", 512'(bus.out_valid), 512'(0));
      check("rst_err", 512'(bus.out_err), 512'(0));
      check("rst_data", 512'(bus.out_data), 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 512'(bus.in_ready), 512'(1));

      // Boundary operands.
      directed("zero", '0);
      directed("m_minus_1", M - 1);
      directed("m", M);
      directed("m_plus_5", M + 5);
      check("m_plus_5_carry", 512'(model_data(M + 5) & carry_mask), 512'(0));
      directed("3m_plus_7", M * 3 + 7);
      directed("4m_minus_1", M4 - 1);
      directed("4m_err", M4);
      directed("huge_err", {W{1'b1}});

      // Back-pressure: result held, new operand waits, accepted on the out_ready cycle.
      run_op(M * 2 + 3, lat);
      check("bp_lat", 512'(lat), 512'(3));
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 11;
         #1;
         check("bp_valid", 512'(bus.out_valid), 512'(1));
         check("bp_data", 512'(bus.out_data), 512'(model_data(3)));
         check("bp_in_ready", 512'(bus.in_ready), 512'(0));
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_pass_ready", 512'(bus.in_ready), 512'(1));
      @(negedge clk);
      check("bp_next_busy", 512'(busy), 512'(1));
      check("bp_next_valid", 512'(bus.out_valid), 512'(0));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      wait_result(lat);
      check("bp2_lat", 512'(lat), 512'(1));
      check("bp2_data", 512'(bus.out_data), 512'(model_data(11)));
      drain();

      // Reset in the middle of a reduction.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = M * 3 + 1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("mid_busy", 512'(busy), 512'(1));
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", 512'(bus.out_valid), 512'(0));
      check("mid_rst_busy", 512'(busy), 512'(0));
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("mid_no_stale", 512'(bus.out_valid), 512'(0));
      end
      directed("after_rst_9", 9);

      // Random stream with back-pressure against the scoreboard.
      sent = 0;
      cyc  = 0;
      while ((sent < NOps || exp_q.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         bus.in_valid = (sent < NOps) && ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 15))
            0:       op = rand_w();
            1:       op = M4 - 1;
            2:       op = M;
            default: op = rand_w() % M4;
         endcase
         bus.in_data   = op;
         bus.out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("rnd_unexpected", 512'(1), 512'(0));
            end else begin
               check("rnd_data", 512'(bus.out_data), 512'(exp_q.pop_front()));
               check("rnd_err", 512'(bus.out_err), 512'(err_q.pop_front()));
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model_data(op));
            err_q.push_back(op >= M4);
            sent++;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("rnd_sent", 512'(sent), 512'(NOps));
      check("rnd_drained", 512'(exp_q.size()), 512'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
